block_averager: RTL and testbench
=================================

Name: block_averager

Overview:
- Accumulates a block of 2**LOG2_SAMPLES unsigned input samples and emits one result per block: the truncated mean, sum >> LOG2_SAMPLES.
- Divides by a power of two using a right shift; fractional results are always rounded down.
- Sits directly upstream of downstream scaling/shift stages and feeds them one averaged word per block over a valid/ready handshake.

Parameters:
- N, 8, width of input samples and of the averaged output.
- LOG2_SAMPLES, 2, log2 of block length (block = 4 samples by default); legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort: discard partial block and any held result
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  N  unsigned sample
- out_valid  output  1  out_data holds a completed average
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  N  averaged result, sum >> LOG2_SAMPLES

Behaviour:
- Reset (rstN low, asynchronous assert, synchronous release):
  - state=ACCUM, sum=0, count=0.
  - Outputs: out_valid=0, out_data=0, in_ready=1 (combinational from state).
- Internal sum register: N+LOG2_SAMPLES bits unsigned, so it never overflows. count register: LOG2_SAMPLES bits.
- FSM state ACCUM:
  - in_ready=1.
  - Accept = in_valid && in_ready.
  - On accept with count < 2**LOG2_SAMPLES-1: sum += in_data, count++.
  - On accept with count == 2**LOG2_SAMPLES-1 (last sample):
    - out_data <= (sum + in_data) >> LOG2_SAMPLES.
    - sum <= 0, count <= 0.
    - out_valid <= 1, go to HOLD.
  - in_valid low: no change. Gaps between samples are allowed at any point.
- FSM state HOLD:
  - in_ready=0, out_valid=1.
  - out_data stays stable until the handshake completes.
  - out_valid && out_ready: out_valid <= 0, go to ACCUM. in_ready returns to 1 on the next cycle.
  - No same-cycle accept of a new sample while in HOLD; this gives one bubble per block.
- Latency: out_valid asserts on the first clk edge after the last sample is accepted (1 cycle).
- Throughput: at most one block per 2**LOG2_SAMPLES+1 cycles.
- clear has priority over every other event in the same cycle:
  - sum=0, count=0, out_valid=0, state=ACCUM.
  - A sample presented in the same cycle is discarded.
  - out_data keeps its last value, but it is meaningless while out_valid=0.
- Reset mid-block or mid-HOLD: the partial sum and the held result are lost. The next full block averages correctly.
- Truncation: the low LOG2_SAMPLES bits of the sum are dropped, with no rounding. The result always fits in N bits (max sum >> K = 2**N-1).

Test Plan (N=8, LOG2_SAMPLES=2):
1. Samples 10,11,12,13 back-to-back, out_ready=1 -> out_valid one cycle after 13 accepted, out_data=11 (46>>2); in_ready low exactly one cycle.
2. Four samples of 255 -> out_data=255 (sum 1020 held without overflow); then 0,0,0,3 -> out_data=0 (truncation).
3. Block 1,2,3,4 with out_ready held low 5 cycles -> out_valid=1 and out_data=2 stable throughout, in_ready=0, in_valid pulses ignored; out_ready high -> out_valid drops next cycle.
4. in_valid toggling every other cycle for samples 100,200,40,60 -> out_data=100; count advances only on accepted cycles.
5. Accept 50,50,50, assert clear on the same cycle as sample 50 -> sample dropped, no output; then 8,8,8,9 -> out_data=8.
6. Accept 2 samples, pulse rstN low mid-cycle -> outputs reset immediately (out_valid=0, in_ready=1); then 4,4,4,4 -> out_data=4.

Source files
------------

// File: rtl/block_averager.sv
// block_averager: accumulates 2**LOG2_SAMPLES unsigned samples and emits
// their truncated mean (sum >> LOG2_SAMPLES) over a valid/ready handshake.
// A completed result is held in HOLD until the consumer takes it. No samples
// are accepted in HOLD, which gives one bubble cycle per block.
module block_averager #(
    parameter int N            = 8,
    parameter int LOG2_SAMPLES = 2
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    localparam int K = LOG2_SAMPLES;
    localparam int SW = N + K;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t          state, nxt;
    logic [SW-1:0]   sum;
    logic [K-1:0]    count;
    logic [SW-1:0]   sum_next;
    logic            accept;
    logic            last;

    assign accept   = in_valid && in_ready;
    assign last     = (count == {K{1'b1}});
    // The sum is wide enough for a full block of maximum samples.
    assign sum_next = sum + {{K{1'b0}}, in_data};

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= ACCUM;
        else       state <= nxt;
    end

    // Next-state logic. clear overrides every other event.
    always_comb begin
        nxt = state;
        if (clear) begin
            nxt = ACCUM;
        end else begin
            case (state)
                ACCUM: if (accept && last) nxt = HOLD;
                HOLD:  if (out_ready)      nxt = ACCUM;
                default: nxt = ACCUM;
            endcase
        end
    end

    // Handshake outputs are decoded from the state.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    // Datapath: accumulate samples, latch the mean on the last sample.
    // clear leaves out_data alone because it is ignored while out_valid is low.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sum      <= '0;
            count    <= '0;
            out_data <= '0;
        end else if (clear) begin
            sum   <= '0;
            count <= '0;
        end else if (accept) begin
            if (last) begin
                out_data <= sum_next[SW-1:K];
                sum      <= '0;
                count    <= '0;
            end else begin
                sum   <= sum_next;
                count <= count + K'(1);
            end
        end
    end

endmodule

// File: tb/tb_block_averager.sv
// Self-checking bench for block_averager (N=8, LOG2_SAMPLES=2).
// Expected averages are pushed to a queue as each block is driven and popped
// when the DUT presents out_valid.
module tb_block_averager;

    localparam int N = 8;
    localparam int K = 2;

    logic         clk = 1'b0;
    logic         rstN;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    int tests  = 0;
    int failed = 0;
    logic [N-1:0] exp_q[$];

    block_averager #(.N(N), .LOG2_SAMPLES(K)) dut (
        .clk(clk), .rstN(rstN), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Present one sample at the next falling edge; it is taken on the rising edge.
    task automatic send(input logic [N-1:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    // Reference mean of four samples, pushed to the scoreboard.
    task automatic push4(input int a, input int b, input int c, input int d);
        int s;
        s = a + b + c + d;
        exp_q.push_back(N'(s / 4));
    endtask

    task automatic test_reset;
        rstN = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failed++;
            $display("FAIL reset: out_valid=%b in_ready=%b out_data=%0d, want 0 1 0",
                     out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    // After the last sample has been driven, drop in_valid, check 1-cycle
    // latency, then pop and compare the result.
    task automatic finish_block(input string name);
        logic [N-1:0] e;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL %s_latency: out_valid=%b in_ready=%b, want 1 0", name, out_valid, in_ready);
        end
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL %s_scoreboard: got out_data=%0d, want an expected entry", name, out_data);
        end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
                failed++;
                $display("FAIL %s_data: out_data=%0d, want %0d", name, out_data, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        push4(10, 11, 12, 13);
        send(10); send(11); send(12); send(13);
        finish_block("b2b");
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL b2b_bubble: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_extremes;
        out_ready = 1'b1;
        push4(255, 255, 255, 255);
        send(255); send(255); send(255); send(255);
        finish_block("max");
        @(negedge clk);
        push4(0, 0, 0, 3);
        send(0); send(0); send(0); send(3);
        finish_block("trunc");
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [N-1:0] e;
        out_ready = 1'b0;
        push4(1, 2, 3, 4);
        e = 8'd2;
        send(1); send(2); send(3); send(4);
        finish_block("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'd99;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL bp_hold%0d: out_valid=%b out_data=%0d in_ready=%b, want 1 %0d 0",
                         i, out_valid, out_data, in_ready, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_gaps;
        out_ready = 1'b1;
        push4(100, 200, 40, 60);
        send(100); @(negedge clk); in_valid = 1'b0;
        send(200); @(negedge clk); in_valid = 1'b0;
        send(40);  @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL gaps_early: out_valid=%b after 3 accepts, want 0", out_valid);
        end
        send(60);
        finish_block("gaps");
        @(negedge clk);
    endtask

    task automatic test_clear;
        out_ready = 1'b1;
        send(50); send(50); send(50);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd50; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failed++;
                $display("FAIL clear_idle%0d: out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
            end
            @(negedge clk);
        end
        push4(8, 8, 8, 9);
        send(8); send(8); send(8); send(9);
        finish_block("clear");
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        send(7); send(7);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rstN = 1'b1;
        push4(4, 4, 4, 4);
        send(4); send(4); send(4); send(4);
        finish_block("rst_mid");
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_extremes();
        test_backpressure();
        test_gaps();
        test_clear();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard stop in case the bench itself wedges.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
